// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_right_ctrl sequencing stage.
// Holds the controller state encoding, the default widths, and the maximum
// amount the downstream 4-bit shifter can apply in a single pass.
package shift_ctrl_pkg;

  localparam int WIDTH_DEF    = 20;
  localparam int SH_BITS_DEF  = 4;
  localparam int AMT_BITS_DEF = 5;

  // Largest amount one pass through the shifter can apply.
  localparam int PASS_MAX = (1 << SH_BITS_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/shift_right_ctrl.sv
// shift_right_ctrl: sequences a 0..31 logical right shift over a registered
// shifter that can only move 0..15 positions per pass. Each registered pass
// result is fed back as the next operand until the full amount is applied.
// The final value is then presented with zero and carry flags on a
// valid/ready response interface.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_a, req_amt        operand and total right-shift amount
//   sh_a, sh_b            registered operand/amount driven to the shifter
//   sh_c                  shifter result, valid one edge after sh_a/sh_b
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              shifted result
//   rsp_zero, rsp_carry   result-is-zero flag, last bit shifted out
module shift_right_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SH_BITS  = SH_BITS_DEF,
  parameter int AMT_BITS = AMT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [AMT_BITS-1:0] req_amt,
  output logic [WIDTH-1:0]    sh_a,
  output logic [SH_BITS-1:0]  sh_b,
  input  logic [WIDTH-1:0]    sh_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_zero,
  output logic                rsp_carry
);

  localparam int PASS_LIM = (1 << SH_BITS) - 1;

  state_t                state, state_nxt;
  logic [AMT_BITS-1:0]   remaining;
  logic                  carry_q;
  logic                  accept;
  logic [SH_BITS-1:0]    acc_pass;
  logic [SH_BITS-1:0]    cap_pass;

  // Amount for the next pass: whatever is left, capped at the shifter range.
  function automatic logic [SH_BITS-1:0] pass_amt(input logic [AMT_BITS-1:0] r);
    if (r > AMT_BITS'(PASS_LIM)) return SH_BITS'(PASS_LIM);
    return r[SH_BITS-1:0];
  endfunction

  function automatic logic [AMT_BITS-1:0] widen(input logic [SH_BITS-1:0] p);
    return {{(AMT_BITS - SH_BITS){1'b0}}, p};
  endfunction

  // Last bit shifted out of the original operand; nothing leaves for a zero
  // shift, and only zeros leave once the shift runs past the operand width.
  function automatic logic carry_of(input logic [WIDTH-1:0]    a,
                                    input logic [AMT_BITS-1:0] amt);
    logic [WIDTH-1:0] t;
    if ((amt == '0) || (int'(amt) > WIDTH)) return 1'b0;
    t = a >> (amt - AMT_BITS'(1));
    return t[0];
  endfunction

  assign acc_pass = pass_amt(req_amt);
  assign cap_pass = pass_amt(remaining);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = (remaining != '0) ? ISSUE : DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; ready is masked during reset because reset forces IDLE.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    accept    = req_ready && req_valid;
  end

  // Shifter drive and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      remaining <= '0;
      carry_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sh_a      <= req_a;
            sh_b      <= acc_pass;
            remaining <= req_amt - widen(acc_pass);
            carry_q   <= carry_of(req_a, req_amt);
          end
        end
        CAPTURE: begin
          if (remaining != '0) begin
            // Feed the partial result back for another pass.
            sh_a      <= sh_c;
            sh_b      <= cap_pass;
            remaining <= remaining - widen(cap_pass);
          end else begin
            rsp_data  <= sh_c;
            rsp_zero  <= (sh_c == '0);
            rsp_carry <= carry_q;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_ctrl.sv
module tb_shift_right_ctrl;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [4:0]    req_amt;
  logic [W-1:0]  sh_a;
  logic [3:0]    sh_b;
  logic [W-1:0]  sh_c;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero;
  logic          rsp_carry;

  shift_right_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_amt   (req_amt),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_c      (sh_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  // Peer shifter: registered logical right shift, no reset.
  always @(posedge clk) sh_c <= sh_a >> sh_b;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
    int           acc;
    int           np;
    int           p[3];
    int           cum[3];
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bp_mode  = 0;   // 0 random ready, 1 hold low, 2 hold high
  bit   seen     = 0;
  bit   post_hs  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: whole shift in one step, passes from the 15-per-pass rule.
  function automatic exp_t model(input logic [W-1:0] a, input int amt);
    exp_t e;
    int   rem;
    int   sum;
    logic [31:0] wide;
    wide    = {12'd0, a};
    e.a     = a;
    e.data  = W'(wide >> amt);
    e.zero  = (e.data == '0);
    e.carry = (amt >= 1 && amt <= W) ? wide[amt-1] : 1'b0;
    e.np    = 0;
    rem     = amt;
    sum     = 0;
    for (int i = 0; i < 3; i++) begin e.p[i] = 0; e.cum[i] = 0; end
    do begin
      e.cum[e.np] = sum;
      e.p[e.np]   = (rem > 15) ? 15 : rem;
      sum        += e.p[e.np];
      rem        -= e.p[e.np];
      e.np++;
    end while (rem > 0);
    e.acc = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (post_hs) begin
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_ready", req_ready, 1);
        post_hs = 0;
      end
      if (q.size() == 0) begin
        if (rsp_valid) chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        exp_t f;
        int   k;
        f = q[0];
        k = cyc - f.acc;
        if (k >= 0 && (k % 2) == 0 && (k / 2) < f.np) begin
          chk("sh_b_pass", sh_b, f.p[k/2]);
          chk("sh_a_pass", sh_a, W'({12'd0, f.a} >> f.cum[k/2]));
        end
        if (rsp_valid) begin
          if (!seen) begin
            chk("latency", k, 2 * f.np);
            seen = 1;
          end
          chk("rsp_data", rsp_data, f.data);
          chk("rsp_zero", rsp_zero, f.zero);
          chk("rsp_carry", rsp_carry, f.carry);
          chk("ready_in_done", req_ready, 0);
          if (rsp_ready) begin
            void'(q.pop_front());
            seen    = 0;
            post_hs = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input int amt);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_amt   = 5'(amt);
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    e     = model(a, amt);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_amt   = 5'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges[9];
    int amt;
    int n;
    edges = '{0, 1, 15, 16, 19, 20, 21, 30, 31};
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_amt   = '0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_sh_a", sh_a, 0);
    chk("rst_sh_b", sh_b, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);

    issue(20'hF0000, 4);
    issue(20'h80001, 1);
    issue(20'hFFFFF, 17);
    issue(20'hFFFFF, 31);
    issue(20'hFFFFF, 20);
    issue(20'hABCDE, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) amt = edges[$urandom_range(0, 8)];
      else                           amt = $urandom_range(0, 31);
      issue(W'($urandom), amt);
    end
    wait_drain();

    // Backpressure, then a back-to-back request once it releases.
    bp_mode = 1;
    issue(20'h12345, 8);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", rsp_valid, 1);
    repeat (5) @(negedge clk);
    bp_mode = 2;
    issue(20'h54321, 16);
    wait_drain();
    bp_mode = 0;

    // Reset during CAPTURE of a two-pass request.
    issue(20'hFFFFF, 17);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    seen    = 0;
    post_hs = 0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_sh_a", sh_a, 0);
    chk("abort_sh_b", sh_b, 0);
    chk("abort_req_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_req_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("no_stale_rsp", rsp_valid, 0);
    issue(20'h00010, 4);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_right_ctrl.md
Name: shift_right_ctrl

Overview:
Sequencing stage directly upstream of the 20-bit registered right-shifter. It accepts a shift request with a 5-bit amount (0..31), which exceeds the shifter's 4-bit range. It drives the shifter in one or more passes of at most 15 positions, feeding each registered result back as the next pass's operand. It then presents the final result, with zero and carry flags, on a valid/ready response interface to ALU writeback.

Parameters:
WIDTH, 20, data width; matches the shifter operand and result width.
SH_BITS, 4, shifter amount width; the maximum per-pass shift is 2^SH_BITS-1 = 15.
AMT_BITS, 5, request shift-amount width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_a  in  WIDTH  operand to shift.
req_amt  in  AMT_BITS  total logical right-shift amount.
sh_a  out  WIDTH  operand to shifter input a (registered).
sh_b  out  SH_BITS  pass amount to shifter input b (registered).
sh_c  in  WIDTH  shifter output c; valid one posedge after sh_a/sh_b change.
rsp_valid  out  1  result available.
rsp_ready  in  1  downstream accepts result.
rsp_data  out  WIDTH  shifted result.
rsp_zero  out  1  rsp_data == 0.
rsp_carry  out  1  last bit shifted out.

Behaviour:
- Reset (async, immediate): state=IDLE; rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_carry=0, sh_a=0, sh_b=0; internal remaining=0. req_ready=0 while rst is high.
- States:
  - IDLE: req_ready=1. On req_valid at a posedge: sh_a<=req_a; sh_b<=min(req_amt,15); remaining<=req_amt-min(req_amt,15); carry latched; go to ISSUE.
  - ISSUE: one wait cycle while the shifter registers sh_c. Go to CAPTURE unconditionally.
  - CAPTURE: sample sh_c.
    - If remaining>0: sh_a<=sh_c; sh_b<=min(remaining,15); remaining -= that amount; go to ISSUE.
    - Otherwise: rsp_data<=sh_c; rsp_zero<=(sh_c==0); rsp_valid<=1; go to DONE.
  - DONE: hold all rsp_* outputs stable. On rsp_ready: rsp_valid<=0; go to IDLE.
- req_ready is high only in IDLE. No request is accepted in the same cycle a response handshakes; the next accept is possible one cycle later.
- Pass count:
  - amt 0..15: 1 pass.
  - amt 16..30: 2 passes.
  - amt 31: 3 passes (15, 15, 1).
  - amt=0 still takes one pass with b=0.
- Latency: rsp_valid rises 2*passes cycles after the accepting edge, i.e. 2, 4 or 6 cycles.
- Carry: req_a[req_amt-1] for 1<=req_amt<=WIDTH; 0 for req_amt=0 or req_amt>WIDTH. Computed from the original operand at accept time.
- Amounts >= WIDTH produce rsp_data=0 naturally through the passes; no special-case datapath.
- The shifter has no reset. Its stale output after reset is never sampled, because sh_c is read only in CAPTURE.
- Reset mid-operation aborts the request, and no response is produced.
- Width rules: pass amounts are unsigned; remaining never underflows because each pass is min(remaining,15).

Decomposition:
- Package shift_ctrl_pkg holds:
  - state enum {IDLE, ISSUE, CAPTURE, DONE}
  - PASS_MAX = 15
  - WIDTH, SH_BITS and AMT_BITS defaults
- No internal sub-module. The shift_right instance stays a peer at the ALU level, wired sh_a->a, sh_b->b, c->sh_c, sharing clk.

Test Plan:
- req_a=0xF0000, amt=4 -> rsp_data=0x0F000, zero=0, carry=0; rsp_valid 2 cycles after accept; sh_b=4.
- req_a=0x80001, amt=1 -> rsp_data=0x40000, carry=1, zero=0; latency 2.
- req_a=0xFFFFF, amt=17 -> sh_b sequence 15 then 2; rsp_data=0x00007, carry=1; latency 4.
- req_a=0xFFFFF, amt=31 -> sh_b sequence 15, 15, 1; rsp_data=0, zero=1, carry=0; latency 6. Same operand with amt=20 -> rsp_data=0, zero=1, carry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout. Raise rsp_ready -> rsp_valid=0 and req_ready=1 the next cycle; back-to-back request then accepted.
- Assert rst during CAPTURE of an amt=17 request -> rsp_valid=0 and sh_a/sh_b=0 immediately, no response. After release, req_ready=1, and request a=0x00010, amt=4 returns 0x00001, carry=0.
